// File: rtl/regs_arb.sv
// Register-file write/read arbiter between the core writeback port and a debug port.
// The core always wins; a single buffered debug access waits, and stalls the core if starved.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | grant offered; a debug request is captured into the buffer
// PEND  | buffered access waiting for a cycle without core writeback
// HOLD  | starved: hold_o asserted until the core leaves a free cycle
// RESP  | completion pulse on dbg_rvalid_o, then back to IDLE
module regs_arb #(
   parameter int STARVE_MAX = 8,
   parameter int AW         = 5,
   parameter int DW         = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_we_i,
   input  logic [AW-1:0] ex_waddr_i,
   input  logic [DW-1:0] ex_wdata_i,
   input  logic          dbg_req_i,
   input  logic          dbg_we_i,
   input  logic [AW-1:0] dbg_addr_i,
   input  logic [DW-1:0] dbg_wdata_i,
   output logic          dbg_gnt_o,
   output logic          dbg_rvalid_o,
   output logic [DW-1:0] dbg_rdata_o,
   output logic          hold_o,
   output logic          rf_we_o,
   output logic [AW-1:0] rf_waddr_o,
   output logic [DW-1:0] rf_wdata_o,
   output logic [AW-1:0] rf_raddr_o,
   input  logic [DW-1:0] rf_rdata_i
);

   typedef enum logic [1:0] {IDLE, PEND, HOLD, RESP} state_e;

   localparam logic [8:0] STARVE_LIM = 9'(STARVE_MAX);

   state_e        state_q, state_d;
   logic          buf_we_q, buf_we_d;
   logic [AW-1:0] buf_addr_q, buf_addr_d;
   logic [DW-1:0] buf_data_q, buf_data_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [8:0]    cnt_inc;
   logic          exec;
   logic          buf_zero;

   assign buf_zero = (buf_addr_q == '0);
   assign cnt_inc  = {1'b0, cnt_q} + 9'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         buf_we_q   <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         cnt_q      <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         buf_we_q   <= buf_we_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      buf_we_d   = buf_we_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      exec       = 1'b0;
      dbg_gnt_o  = 1'b0;
      case (state_q)
         IDLE: begin
            dbg_gnt_o = 1'b1;
            if (dbg_req_i) begin
               buf_we_d   = dbg_we_i;
               buf_addr_d = dbg_addr_i;
               buf_data_d = dbg_wdata_i;
               cnt_d      = '0;
               state_d    = PEND;
            end
         end
         PEND: begin
            if (ex_we_i) begin
               cnt_d = cnt_inc[8] ? 8'hFF : cnt_inc[7:0];
               if (cnt_inc >= STARVE_LIM) state_d = HOLD;
            end else begin
               exec    = 1'b1;
               state_d = RESP;
            end
         end
         HOLD: begin
            if (!ex_we_i) begin
               exec    = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Register x0 reads as zero regardless of what the file returns.
      if (exec && !buf_we_q) rdata_d = buf_zero ? '0 : rf_rdata_i;
   end

   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = ex_waddr_i;
      rf_wdata_o = ex_wdata_i;
      if (ex_we_i) begin
         rf_we_o = rst;
      end else if (exec) begin
         rf_we_o    = buf_we_q && !buf_zero;
         rf_waddr_o = buf_addr_q;
         rf_wdata_o = buf_data_q;
      end
   end

   assign rf_raddr_o   = (state_q == IDLE) ? dbg_addr_i : buf_addr_q;
   assign hold_o       = (state_q == HOLD);
   assign dbg_rvalid_o = (state_q == RESP);
   assign dbg_rdata_o  = rdata_q;

endmodule

// File: tb/tb_regs_arb.sv
// Bench for regs_arb: transaction-level model compared every cycle on the falling edge,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_regs_arb;
   localparam int SM = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_we = 1'b0;
   logic [4:0]  ex_waddr = '0;
   logic [31:0] ex_wdata = '0;
   logic        dbg_req = 1'b0;
   logic        dbg_we = 1'b0;
   logic [4:0]  dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic        dbg_gnt_o, dbg_rvalid_o, hold_o, rf_we_o;
   logic [31:0] dbg_rdata_o, rf_wdata_o, rf_rdata_i;
   logic [4:0]  rf_waddr_o, rf_raddr_o;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] env_mem [32] = '{default: '0};
   logic [31:0] m_mem [32] = '{default: '0};

   regs_arb #(.STARVE_MAX(SM), .AW(5), .DW(32)) dut (
      .clk(clk), .rst(rst_n),
      .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
      .hold_o(hold_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i)
   );

   always #5 clk = ~clk;

   assign rf_rdata_i = env_mem[rf_raddr_o];
   always @(posedge clk) if (rf_we_o) env_mem[rf_waddr_o] <= rf_wdata_o;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Model: an outstanding access, its blocked-cycle count, and a due completion.
   logic        m_pend = 1'b0, m_resp = 1'b0, m_bwe = 1'b0;
   logic [4:0]  m_baddr = '0;
   logic [31:0] m_bdata = '0, m_rdata = '0;
   int          m_blk = 0;
   logic        e_gnt, e_hold, e_we, m_exec;
   logic [4:0]  e_wa;
   logic [31:0] e_wd;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_rf_we", {31'd0, rf_we_o}, 32'd0);
         chk("rst_hold", {31'd0, hold_o}, 32'd0);
         chk("rst_rvalid", {31'd0, dbg_rvalid_o}, 32'd0);
         chk("rst_rdata", dbg_rdata_o, 32'd0);
         m_pend = 1'b0; m_resp = 1'b0; m_blk = 0; m_rdata = '0;
      end else begin
         e_gnt  = !m_pend && !m_resp;
         e_hold = m_pend && (m_blk >= SM);
         m_exec = m_pend && !ex_we;
         e_we   = ex_we || (m_exec && m_bwe && (m_baddr != 5'd0));
         e_wa   = ex_we ? ex_waddr : m_baddr;
         e_wd   = ex_we ? ex_wdata : m_bdata;
         chk("gnt", {31'd0, dbg_gnt_o}, {31'd0, e_gnt});
         chk("rvalid", {31'd0, dbg_rvalid_o}, {31'd0, m_resp});
         chk("hold", {31'd0, hold_o}, {31'd0, e_hold});
         chk("rf_we", {31'd0, rf_we_o}, {31'd0, e_we});
         chk("rdata", dbg_rdata_o, m_rdata);
         if (e_we) begin
            chk("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, e_wa});
            chk("rf_wdata", rf_wdata_o, e_wd);
         end
         if (m_pend || m_resp) chk("rf_raddr", {27'd0, rf_raddr_o}, {27'd0, m_baddr});
         if (m_resp) begin
            m_resp = 1'b0;
         end else if (m_pend) begin
            if (ex_we) begin
               if (m_blk < SM) m_blk++;
            end else begin
               if (!m_bwe) m_rdata = (m_baddr == 5'd0) ? 32'd0 : m_mem[m_baddr];
               m_pend = 1'b0;
               m_resp = 1'b1;
            end
         end else if (dbg_req) begin
            m_bwe = dbg_we; m_baddr = dbg_addr; m_bdata = dbg_wdata;
            m_pend = 1'b1; m_blk = 0;
         end
         if (e_we) m_mem[e_wa] = e_wd;
      end
   end

   task automatic cyc(input logic rs, input logic ew, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rq, input logic dw, input logic [4:0] da, input logic [31:0] dd);
      @(posedge clk);
      #1;
      rst_n = rs; ex_we = ew; ex_waddr = wa; ex_wdata = wd;
      dbg_req = rq; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
      #1;
   endtask

   int g_cnt, v_cnt, prob;

   initial begin
      cyc(0, 1, 5'd4, 32'h1111, 0, 0, 0, 0);
      chk("lit_rst_we_gated", {31'd0, rf_we_o}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      // Debug write x5, then read it back
      cyc(1, 0, 0, 0, 1, 1, 5'd5, 32'hDEADBEEF);
      chk("lit_w5_gnt", {31'd0, dbg_gnt_o}, 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_w5_we", {31'd0, rf_we_o}, 32'd1);
      chk("lit_w5_addr", {27'd0, rf_waddr_o}, 32'd5);
      chk("lit_w5_data", rf_wdata_o, 32'hDEADBEEF);
      chk("lit_w5_novalid", {31'd0, dbg_rvalid_o}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_w5_rvalid", {31'd0, dbg_rvalid_o}, 32'd1);
      cyc(1, 0, 0, 0, 1, 0, 5'd5, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_r5_rvalid", {31'd0, dbg_rvalid_o}, 32'd1);
      chk("lit_r5_rdata", dbg_rdata_o, 32'hDEADBEEF);
      // x0: read returns zero, write is dropped but completes
      cyc(1, 0, 0, 0, 1, 0, 5'd0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_r0_rvalid", {31'd0, dbg_rvalid_o}, 32'd1);
      chk("lit_r0_rdata", dbg_rdata_o, 32'd0);
      cyc(1, 0, 0, 0, 1, 1, 5'd0, 32'h12345678);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_w0_we", {31'd0, rf_we_o}, 32'd0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_w0_rvalid", {31'd0, dbg_rvalid_o}, 32'd1);
      chk("lit_w0_rdata_kept", dbg_rdata_o, 32'd0);
      // Starvation: 20 blocked cycles, hold after 8
      cyc(1, 0, 0, 0, 1, 1, 5'd6, 32'hCAFE0006);
      for (int i = 1; i <= 20; i++) begin
         cyc(1, 1, 5'd9, 32'h900 + i, 0, 0, 0, 0);
         chk("lit_starve_hold", {31'd0, hold_o}, (i > SM) ? 32'd1 : 32'd0);
         chk("lit_starve_core", {27'd0, rf_waddr_o}, 32'd9);
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_hold_exec_hold", {31'd0, hold_o}, 32'd1);
      chk("lit_hold_exec_addr", {27'd0, rf_waddr_o}, 32'd6);
      chk("lit_hold_exec_data", rf_wdata_o, 32'hCAFE0006);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_hold_fall", {31'd0, hold_o}, 32'd0);
      chk("lit_hold_rvalid", {31'd0, dbg_rvalid_o}, 32'd1);
      // Core write to x3 in the grant cycle
      cyc(1, 1, 5'd3, 32'h33, 1, 1, 5'd7, 32'h77);
      chk("lit_gx_gnt", {31'd0, dbg_gnt_o}, 32'd1);
      chk("lit_gx_core_addr", {27'd0, rf_waddr_o}, 32'd3);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_gx_dbg_addr", {27'd0, rf_waddr_o}, 32'd7);
      chk("lit_gx_dbg_data", rf_wdata_o, 32'h77);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      // Reset while in HOLD drops the access
      cyc(1, 0, 0, 0, 1, 1, 5'd8, 32'hBAD0BAD0);
      for (int i = 1; i <= SM + 1; i++) cyc(1, 1, 5'd10, 32'hA0 + i, 0, 0, 0, 0);
      chk("lit_pre_rst_hold", {31'd0, hold_o}, 32'd1);
      cyc(0, 1, 5'd10, 32'hAA, 0, 0, 0, 0);
      chk("lit_rst_hold", {31'd0, hold_o}, 32'd0);
      chk("lit_rst_we", {31'd0, rf_we_o}, 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 0, 0, 0);
         chk("lit_post_rst_rvalid", {31'd0, dbg_rvalid_o}, 32'd0);
         chk("lit_post_rst_we", {31'd0, rf_we_o}, 32'd0);
      end
      cyc(1, 0, 0, 0, 1, 0, 5'd5, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      chk("lit_after_rst_rdata", dbg_rdata_o, 32'hDEADBEEF);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      // Back-to-back requests held high
      g_cnt = 0; v_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1, 0, 0, 0, 1, 0, 5'(i), 0);
         if (dbg_gnt_o) g_cnt++;
         if (dbg_rvalid_o) v_cnt++;
      end
      chk("lit_b2b_grants", g_cnt, 32'd4);
      chk("lit_b2b_rvalids", v_cnt, 32'd4);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      // Randomized traffic with varying core load and occasional reset
      prob = 50;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) prob = $urandom_range(0, 3) * 33;
         cyc(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1,
             ($urandom_range(0, 99) < prob) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom);
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
